frame_sequencer: RTL and testbench

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_sequencer.sv | 176 +++++++++++++++++
 tb/tb_frame_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// Trigger-driven sequencer that launches a chain of processing stages, with a per-stage
// watchdog abort, an optional one-deep trigger queue and frame/drop/timeout status.
//   state | meaning
//   IDLE  | waiting for a trigger or a queued trigger
//   DELAY | counting down the start delay before stage 0
//   RUN   | stage k running, watchdog counting
//   DONE  | last stage finished, frameDone pulse out
module frame_sequencer #(
    parameter int STAGES      = 3,
    parameter int START_DELAY = 4,
    parameter int TIMEOUT     = 65535,
    parameter int QUEUE_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trigger,
    input  logic [STAGES-1:0] stageDone,
    input  logic              clrStatus,
    output logic [STAGES-1:0] stageStart,
    output logic              frameDone,
    output logic              busy,
    output logic [15:0]       frameCount,
    output logic [15:0]       dropCount,
    output logic              timeoutFlag,
    output logic [2:0]        timeoutStage
);

    typedef enum logic [1:0] {IDLE, DELAY, RUN, DONE} state_t;

    // DELAY covers START_DELAY-1 cycles; the launch edge itself supplies the last one.
    localparam logic [7:0]  DLY_LOAD = 8'((START_DELAY > 1) ? START_DELAY - 2 : 0);
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);
    localparam logic [2:0]  LAST_K   = 3'(STAGES - 1);

    state_t            state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic              pending_q, pending_d;
    logic [7:0]        dly_q, dly_d;
    logic [15:0]       wd_q, wd_d;
    logic [STAGES-1:0] stage_start_q, stage_start_d;
    logic              frame_done_q, frame_done_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic [15:0]       drop_count_q, drop_count_d;
    logic              timeout_flag_q, timeout_flag_d;
    logic [2:0]        timeout_stage_q, timeout_stage_d;

    logic       start_frame, done_k, drop, abort, launch;
    logic [2:0] launch_k;

    always_comb begin
        state_d         = state_q;
        k_d             = k_q;
        pending_d       = pending_q;
        dly_d           = dly_q;
        wd_d            = wd_q;
        stage_start_d   = '0;
        frame_done_d    = 1'b0;
        frame_count_d   = frame_count_q;
        drop_count_d    = drop_count_q;
        timeout_flag_d  = timeout_flag_q;
        timeout_stage_d = timeout_stage_q;
        drop            = 1'b0;
        abort           = 1'b0;
        launch          = 1'b0;
        launch_k        = '0;

        // stageDone[k] is ignored while stage k's own start pulse is still out.
        done_k = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (k_q == 3'(i)) done_k = stageDone[i] && !stage_start_q[i];
        end

        start_frame = (state_q == IDLE) && (trigger || pending_q);
        if (start_frame) pending_d = 1'b0;
        if (trigger && ((state_q != IDLE) || pending_q)) begin
            if ((QUEUE_EN != 0) && (!pending_q || start_frame)) pending_d = 1'b1;
            else drop = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start_frame) begin
                    if (START_DELAY > 1) begin
                        state_d = DELAY;
                        dly_d   = DLY_LOAD;
                    end else begin
                        launch = 1'b1;
                    end
                end
            end
            DELAY: begin
                if (dly_q == 8'd0) launch = 1'b1;
                else dly_d = dly_q - 8'd1;
            end
            RUN: begin
                if (done_k) begin
                    if (k_q == LAST_K) begin
                        state_d       = DONE;
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + 16'd1;
                    end else begin
                        launch   = 1'b1;
                        launch_k = k_q + 3'd1;
                    end
                end else if (wd_q >= WD_LIMIT) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (launch) begin
            state_d = RUN;
            k_d     = launch_k;
            wd_d    = '0;
        end
        for (int i = 0; i < STAGES; i++) begin
            stage_start_d[i] = launch && (launch_k == 3'(i));
        end

        // A drop or abort in the same cycle as clrStatus wins over the clear.
        if (clrStatus) begin
            timeout_flag_d = 1'b0;
            drop_count_d   = '0;
        end
        if (abort) begin
            timeout_flag_d  = 1'b1;
            timeout_stage_d = k_q;
        end
        if (drop) begin
            if (clrStatus) drop_count_d = 16'd1;
            else if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            k_q             <= '0;
            pending_q       <= 1'b0;
            dly_q           <= '0;
            wd_q            <= '0;
            stage_start_q   <= '0;
            frame_done_q    <= 1'b0;
            frame_count_q   <= '0;
            drop_count_q    <= '0;
            timeout_flag_q  <= 1'b0;
            timeout_stage_q <= '0;
        end else begin
            state_q         <= state_d;
            k_q             <= k_d;
            pending_q       <= pending_d;
            dly_q           <= dly_d;
            wd_q            <= wd_d;
            stage_start_q   <= stage_start_d;
            frame_done_q    <= frame_done_d;
            frame_count_q   <= frame_count_d;
            drop_count_q    <= drop_count_d;
            timeout_flag_q  <= timeout_flag_d;
            timeout_stage_q <= timeout_stage_d;
        end
    end

    assign stageStart   = stage_start_q;
    assign frameDone    = frame_done_q;
    assign busy         = (state_q != IDLE);
    assign frameCount   = frame_count_q;
    assign dropCount    = drop_count_q;
    assign timeoutFlag  = timeout_flag_q;
    assign timeoutStage = timeout_stage_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: a default instance (queueing, long watchdog) and a second
// instance with no queue and a 20-cycle watchdog, both driven from the same inputs.
module tb_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst, trigger, clrStatus;
    logic [2:0]  stageDone;
    logic [2:0]  ss_a, ss_b, ts_a, ts_b;
    logic        fd_a, fd_b, busy_a, busy_b, tf_a, tf_b;
    logic [15:0] fc_a, fc_b, dc_a, dc_b;

    frame_sequencer dut_a (
        .clk(clk), .rst(rst), .trigger(trigger), .stageDone(stageDone), .clrStatus(clrStatus),
        .stageStart(ss_a), .frameDone(fd_a), .busy(busy_a), .frameCount(fc_a),
        .dropCount(dc_a), .timeoutFlag(tf_a), .timeoutStage(ts_a)
    );

    frame_sequencer #(.STAGES(3), .START_DELAY(4), .TIMEOUT(20), .QUEUE_EN(0)) dut_b (
        .clk(clk), .rst(rst), .trigger(trigger), .stageDone(stageDone), .clrStatus(clrStatus),
        .stageStart(ss_b), .frameDone(fd_b), .busy(busy_b), .frameCount(fc_b),
        .dropCount(dc_b), .timeoutFlag(tf_b), .timeoutStage(ts_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lat0, lat1, lat2;
        int st0, st1, st2;
        int fd;
        int cnt;
    } vec_t;
    typedef struct { int cyc; int code; } ev_t;
    typedef struct { int c; logic [2:0] m; } dn_t;

    vec_t vecs [4];
    ev_t  exp_q[$];
    int   trig_at[$];
    int   clr_at[$];
    dn_t  done_at[$];
    int   cyc = 0;
    int   t0 = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   sel_b = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (rel cycle %0d)", name, act, req, cyc - t0);
        end
    endtask

    // Pops the next expected pulse; code 0..2 = stageStart bit, 8 = frameDone.
    task automatic match_event(input int code);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pulse_unexpected: event %0d at rel cycle %0d, required no pulse",
                     code, cyc - t0);
        end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.code != code) begin
                n_fail++;
                $display("FAIL pulse_order: event %0d at rel cycle %0d, required event %0d at rel cycle %0d",
                         code, cyc - t0, e.code, e.cyc - t0);
            end
        end
    endtask

    task automatic observe();
        logic [2:0] ss;
        logic       fd;
        ss = sel_b ? ss_b : ss_a;
        fd = sel_b ? fd_b : fd_a;
        for (int i = 0; i < 3; i++) if (ss[i]) match_event(i);
        if (fd) match_event(8);
    endtask

    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int rel, input int code);
        ev_t e;
        e.cyc  = t0 + rel;
        e.code = code;
        exp_q.push_back(e);
    endtask

    task automatic add_done(input int rel, input logic [2:0] m);
        dn_t d;
        d.c = rel;
        d.m = m;
        done_at.push_back(d);
    endtask

    task automatic new_test();
        trig_at.delete();
        clr_at.delete();
        done_at.delete();
        t0 = cyc;
    endtask

    // Default-timing frame: stage done 5 cycles after each start.
    task automatic std_frame();
        trig_at.push_back(0);
        add_done(9, 3'b001);
        add_done(15, 3'b010);
        add_done(21, 3'b100);
        expect_ev(4, 0);
        expect_ev(10, 1);
        expect_ev(16, 2);
        expect_ev(22, 8);
    endtask

    task automatic run_to(input int r);
        int c;
        while (cyc - t0 < r) begin
            c = cyc - t0;
            trigger   = 1'b0;
            clrStatus = 1'b0;
            stageDone = '0;
            foreach (trig_at[j]) if (trig_at[j] == c) trigger = 1'b1;
            foreach (clr_at[j]) if (clr_at[j] == c) clrStatus = 1'b1;
            foreach (done_at[j]) if (done_at[j].c == c) stageDone = stageDone | done_at[j].m;
            step();
        end
        trigger   = 1'b0;
        clrStatus = 1'b0;
        stageDone = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        exp_q.delete();
    endtask

    initial begin
        rst       = 1'b1;
        trigger   = 1'b0;
        clrStatus = 1'b0;
        stageDone = '0;
        //          lat0 lat1 lat2 st0 st1 st2 fd cnt
        vecs[0] = '{5,   5,   5,   4,  10, 16, 22, 1};
        vecs[1] = '{1,   1,   1,   4,  6,  8,  10, 2};
        vecs[2] = '{3,   7,   2,   4,  8,  16, 19, 3};
        vecs[3] = '{2,   9,   1,   4,  7,  17, 19, 4};

        #1 rst = 1'b0;
        #2;
        chk("rst_stage_start", ss_a, 0);
        chk("rst_frame_done", fd_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_frame_count", fc_a, 0);
        chk("rst_drop_count", dc_a, 0);
        chk("rst_timeout_flag", tf_a, 0);
        chk("rst_timeout_stage", ts_a, 0);
        chk("rst_busy_b", busy_b, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();

        // Table-driven frames with varied stage latencies, back to back.
        for (int i = 0; i < 4; i++) begin
            new_test();
            trig_at.push_back(0);
            add_done(vecs[i].st0 + vecs[i].lat0, 3'b001);
            add_done(vecs[i].st1 + vecs[i].lat1, 3'b010);
            add_done(vecs[i].st2 + vecs[i].lat2, 3'b100);
            expect_ev(vecs[i].st0, 0);
            expect_ev(vecs[i].st1, 1);
            expect_ev(vecs[i].st2, 2);
            expect_ev(vecs[i].fd, 8);
            run_to(vecs[i].fd + 3);
            chk("vec_frame_count", fc_a, vecs[i].cnt);
            chk("vec_busy_idle", busy_a, 0);
        end
        chk("vec_pulses_seen", exp_q.size(), 0);

        // Stray stageDone bits: other-stage done, and own done in the start cycle.
        do_reset();
        new_test();
        std_frame();
        add_done(4, 3'b101);
        add_done(6, 3'b100);
        run_to(25);
        chk("stray_frame_count", fc_a, 1);
        chk("stray_pulses_seen", exp_q.size(), 0);

        // Queued trigger plus drops, including a trigger in the DONE cycle.
        do_reset();
        new_test();
        std_frame();
        trig_at.push_back(3);
        trig_at.push_back(8);
        trig_at.push_back(22);
        add_done(32, 3'b001);
        add_done(38, 3'b010);
        add_done(44, 3'b100);
        expect_ev(27, 0);
        expect_ev(33, 1);
        expect_ev(39, 2);
        expect_ev(45, 8);
        run_to(12);
        chk("queue_drop_mid", dc_a, 1);
        run_to(23);
        chk("queue_idle_gap", busy_a, 0);
        run_to(24);
        chk("queue_delay_start", busy_a, 1);
        run_to(48);
        chk("queue_frame_count", fc_a, 2);
        chk("queue_drop_count", dc_a, 2);
        chk("queue_busy_end", busy_a, 0);
        chk("queue_pulses_seen", exp_q.size(), 0);

        // No queue: trigger while busy is dropped; drop beats a same-cycle clear.
        sel_b = 1'b1;
        do_reset();
        new_test();
        std_frame();
        trig_at.push_back(6);
        trig_at.push_back(12);
        clr_at.push_back(12);
        clr_at.push_back(18);
        run_to(10);
        chk("noq_drop_count", dc_b, 1);
        run_to(14);
        chk("noq_drop_with_clr", dc_b, 1);
        run_to(20);
        chk("noq_clr_drop", dc_b, 0);
        run_to(25);
        chk("noq_frame_count", fc_b, 1);
        chk("noq_busy_end", busy_b, 0);
        chk("noq_pulses_seen", exp_q.size(), 0);

        // Watchdog: stage 1 never completes; abort 20 cycles after its start.
        do_reset();
        new_test();
        trig_at.push_back(0);
        add_done(7, 3'b001);
        expect_ev(4, 0);
        expect_ev(8, 1);
        clr_at.push_back(27);
        clr_at.push_back(32);
        run_to(27);
        chk("to_busy_before", busy_b, 1);
        chk("to_flag_before", tf_b, 0);
        run_to(28);
        chk("to_busy_after", busy_b, 0);
        chk("to_flag_set", tf_b, 1);
        chk("to_stage", ts_b, 1);
        chk("to_frame_count", fc_b, 0);
        run_to(34);
        chk("to_flag_cleared", tf_b, 0);
        chk("to_pulses_seen", exp_q.size(), 0);

        // Reset during stage 1 aborts silently; trigger on the first edge after release.
        sel_b = 1'b0;
        do_reset();
        new_test();
        std_frame();
        run_to(25);
        chk("rstmid_first_frame", fc_a, 1);
        new_test();
        trig_at.push_back(0);
        add_done(9, 3'b001);
        expect_ev(4, 0);
        run_to(10);
        chk("rstmid_pre_start", ss_a, 2);
        rst = 1'b0;
        #1;
        chk("rstmid_stage_start", ss_a, 0);
        chk("rstmid_busy", busy_a, 0);
        chk("rstmid_frame_count", fc_a, 0);
        chk("rstmid_frame_done", fd_a, 0);
        chk("rstmid_pulses_seen", exp_q.size(), 0);
        step();
        step();
        rst = 1'b1;
        new_test();
        std_frame();
        run_to(25);
        chk("rstmid_clean_frame", fc_a, 1);
        chk("rstmid_busy_end", busy_a, 0);
        chk("rstmid_clean_pulses", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
